// File: rtl/main_mem_pkg.sv
// main_mem_pkg: shared constants and FSM state type for the main-memory responder.
// Optional feature macro: MEM_BYTE_WRITE_EN (byte-lane write enables).
package main_mem_pkg;

    localparam int MEM_DATA_W = 32;
    localparam int MEM_ADDR_W = 30;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/main_mem_array.sv
// main_mem_array: single-port synchronous word RAM with byte enables and registered read.
// Optional feature macro: MEM_BYTE_WRITE_EN (byte enables driven by the controller).
module main_mem_array
    import main_mem_pkg::*;
#(
    parameter int DATA_W     = MEM_DATA_W,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int BE_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    // Byte-lane write into the backing array
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Read data is captured only on a read and held otherwise
    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem[addr];
        end
    end

    // Read data register
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/main_mem_ctrl.sv
// main_mem_ctrl: fixed-latency main-memory responder for cache fills and writebacks.
// Optional feature macro: MEM_BYTE_WRITE_EN (adds req_be byte-lane write enables).
module main_mem_ctrl
    import main_mem_pkg::*;
#(
    parameter int DATA_W     = MEM_DATA_W,
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
`ifdef MEM_BYTE_WRITE_EN
    input  logic [DATA_W/8-1:0] req_be,
`endif
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_wr,
    output logic              busy
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam bit DIRECT = (LATENCY == 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("main_mem_ctrl: LATENCY must be in 1..15");
    end

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    wr_q, wr_d;
    logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [BE_W-1:0]         be_q, be_d;
    logic                    resp_wr_q, resp_wr_d;

    logic                    accept;
    logic                    fire_direct;
    logic                    fire;
    logic                    mem_en;
    logic                    mem_we;
    logic [DEPTH_LOG2-1:0]   mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [BE_W-1:0]         mem_be;
    logic [BE_W-1:0]         req_be_i;
    logic                    unused_addr_hi;

`ifdef MEM_BYTE_WRITE_EN
    assign req_be_i = req_be;
`else
    assign req_be_i = '1;
`endif

    assign unused_addr_hi = ^req_addr[ADDR_W-1:DEPTH_LOG2];

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    // With unit latency the array access happens on the accept edge itself,
    // so it is fed straight from the request inputs instead of the latches.
    assign fire_direct = DIRECT && accept;
    assign fire = fire_direct || (state_q == WAIT && cnt_q == '0);

    // Next state, counter and request latches
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    wr_d    = req_wr;
                    addr_d  = req_addr[DEPTH_LOG2-1:0];
                    wdata_d = req_wdata;
                    be_d    = req_be_i;
                    cnt_d   = CNT_LOAD;
                    state_d = DIRECT ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Array access port selection; reset suppresses a pending commit
    always_comb begin
        mem_en    = fire && !reset;
        mem_we    = fire_direct ? req_wr : wr_q;
        mem_addr  = fire_direct ? req_addr[DEPTH_LOG2-1:0] : addr_q;
        mem_wdata = fire_direct ? req_wdata : wdata_q;
        mem_be    = fire_direct ? req_be_i : be_q;
        resp_wr_d = fire ? mem_we : resp_wr_q;
    end

    // Control and request-latch registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            resp_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            resp_wr_q <= resp_wr_d;
        end
    end

    main_mem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .en    (mem_en),
        .we    (mem_we),
        .be    (mem_be),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (resp_rdata)
    );

    assign resp_valid = (state_q == RESP);
    assign resp_wr    = resp_wr_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_main_mem_ctrl.sv
// tb_main_mem_ctrl: scoreboard bench for main_mem_ctrl with a word-array reference model.
// Optional feature macro: MEM_BYTE_WRITE_EN (enables byte-lane stimulus).
module tb_main_mem_ctrl;

    localparam int LAT = 4;
    localparam int DW  = 32;
    localparam int AW  = 30;
    localparam int DL  = 10;

    typedef struct {
        logic        wr;
        logic [31:0] data;
        int          ecyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [3:0]    req_be = 4'hF;
    logic          req_ready;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_wr;
    logic          busy;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          busy_until = 0;
    bit          mon_en = 1'b0;
    logic [31:0] last_rd = '0;
    logic [31:0] mem_m [1024];
    exp_t        q [$];

    main_mem_ctrl #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .DEPTH_LOG2 (DL),
        .LATENCY    (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
`ifdef MEM_BYTE_WRITE_EN
        .req_be     (req_be),
`endif
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_wr    (resp_wr),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: handshake timing model and scoreboard pops
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            check("req_ready", 32'(req_ready), 32'(cyc >= busy_until));
            check("busy", 32'(busy), 32'(cyc < busy_until));
            if (resp_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_resp", 32'(resp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("resp_cycle", 32'(cyc), 32'(e.ecyc));
                    check("resp_wr", 32'(resp_wr), 32'(e.wr));
                    if (!e.wr) last_rd = e.data;
                    check("resp_rdata", resp_rdata, last_rd);
                end
            end else begin
                check("rdata_hold", resp_rdata, last_rd);
            end
        end
    end

    task automatic do_reset(input logic with_valid);
        reset = 1'b1;
        req_valid = with_valid;
        req_addr = 30'h33;
        req_wr = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_valid = 1'b0;
        busy_until = cyc;
        last_rd = '0;
        q.delete();
    endtask

    task automatic do_req(input logic wr, input logic [AW-1:0] addr,
                          input logic [31:0] data, input logic [3:0] be,
                          input bit keep, input bit junk, input bit abort);
        bit acc;
        int e0;
        exp_t e;
        logic [9:0] a;
        @(negedge clk);
        req_valid = 1'b1;
        req_wr = wr;
        req_addr = addr;
        req_wdata = data;
        req_be = be;
        acc = 1'b0;
        e0 = 0;
        for (int i = 0; i < 64 && !acc; i++) begin
            if (req_ready) begin
                acc = 1'b1;
                e0 = cyc + 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!acc) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        busy_until = e0 + LAT + 1;
        a = addr[9:0];
`ifndef MEM_BYTE_WRITE_EN
        be = 4'hF;
`endif
        if (!abort) begin
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mem_m[a][b*8 +: 8] = data[b*8 +: 8];
            end
            e.wr = wr;
            e.data = mem_m[a];
            e.ecyc = e0 + LAT;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
        req_addr = AW'($urandom);
        req_wdata = $urandom;
        req_wr = ~wr;
        if (junk) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_addr = addr ^ 30'h7;
            @(negedge clk);
            req_valid = 1'b0;
        end
        if (abort) begin
            do @(negedge clk); while (cyc != e0 + 1);
            do_reset(1'b0);
        end
    endtask

    initial begin
        logic [AW-1:0] ra;
        for (int i = 0; i < 1024; i++) mem_m[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_resp_wr", 32'(resp_wr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        busy_until = cyc;
        mon_en = 1'b1;

        do_req(1'b1, 30'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_req(1'b0, 30'h10, 32'h0, 4'hF, 0, 0, 0);

        do_req(1'b1, 30'h1, 32'h11, 4'hF, 0, 0, 0);
        do_req(1'b1, 30'h2, 32'h22, 4'hF, 0, 0, 0);
        do_req(1'b0, 30'h1, 32'h0, 4'hF, 1, 0, 0);
        do_req(1'b0, 30'h2, 32'h0, 4'hF, 0, 0, 0);

        do_req(1'b1, 30'h405, 32'h5A5A5A5A, 4'hF, 0, 0, 0);
        do_req(1'b0, 30'h005, 32'h0, 4'hF, 0, 0, 0);

        do_req(1'b1, 30'h20, 32'h0, 4'hF, 0, 0, 0);
        do_req(1'b1, 30'h20, 32'h12345678, 4'hF, 0, 0, 1);
        do_req(1'b0, 30'h20, 32'h0, 4'hF, 0, 0, 0);

        do_req(1'b0, 30'h10, 32'h0, 4'hF, 0, 1, 0);

        @(negedge clk);
        do_reset(1'b1);
        repeat (2) @(negedge clk);

`ifdef MEM_BYTE_WRITE_EN
        do_req(1'b1, 30'h30, 32'hAABBCCDD, 4'hF, 0, 0, 0);
        do_req(1'b1, 30'h30, 32'h11223344, 4'b0101, 0, 0, 0);
        do_req(1'b0, 30'h30, 32'h0, 4'h0, 0, 0, 0);
        check("be_model", mem_m[10'h30], 32'hAA22CC44);
        do_req(1'b1, 30'h30, 32'h99999999, 4'h0, 0, 0, 0);
        do_req(1'b0, 30'h30, 32'h0, 4'hF, 0, 0, 0);
`endif

        for (int i = 0; i < 64; i++)
            do_req(1'b1, AW'(i), $urandom, 4'hF, 0, 0, 0);
        for (int i = 0; i < 80; i++) begin
            ra = (AW'($urandom) & 30'h3FFFFC00) | AW'($urandom_range(0, 63));
            do_req(1'($urandom), ra, $urandom, 4'($urandom), 1'($urandom), 0, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
